// File: rtl/apprx_alu_pkg.sv
// Shared types and constants for the approximate ALU datapath.
// Includes the multiplier FSM states, datapath widths and per-step shifts.
package apprx_alu_pkg;

    localparam int unsigned OP_W   = 8;
    localparam int unsigned NIB_W  = 4;
    localparam int unsigned PP_W   = 8;
    localparam int unsigned PROD_W = 16;
    localparam int unsigned STEP_W = 2;

    localparam logic [STEP_W-1:0] STEP_LAST = '1;

    localparam int unsigned SHIFT_S0 = 0;
    localparam int unsigned SHIFT_S1 = 4;
    localparam int unsigned SHIFT_S2 = 4;
    localparam int unsigned SHIFT_S3 = 8;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    function automatic logic [3:0] step_shift(input logic [STEP_W-1:0] step);
        case (step)
            2'd0:    return 4'(SHIFT_S0);
            2'd1:    return 4'(SHIFT_S1);
            2'd2:    return 4'(SHIFT_S2);
            default: return 4'(SHIFT_S3);
        endcase
    endfunction

endpackage

// File: rtl/mul_8x8_apprx_seq_if.sv
// Operand/result handshake bundle for mul_8x8_apprx_seq.
// The exact port exists only when APPRX_MUL_EXACT_EN is defined.
interface mul_8x8_apprx_seq_if;
    import apprx_alu_pkg::*;

    logic              in_valid;
    logic              in_ready;
    logic [OP_W-1:0]   A;
    logic [OP_W-1:0]   B;
`ifdef APPRX_MUL_EXACT_EN
    logic              exact;
`endif
    logic              out_valid;
    logic              out_ready;
    logic [PROD_W-1:0] P;
    logic              busy;

    modport master (
        output in_valid, A, B, out_ready,
`ifdef APPRX_MUL_EXACT_EN
        output exact,
`endif
        input  in_ready, out_valid, P, busy
    );

    modport slave (
        input  in_valid, A, B, out_ready,
`ifdef APPRX_MUL_EXACT_EN
        input  exact,
`endif
        output in_ready, out_valid, P, busy
    );

endinterface

// File: rtl/mul_4x4_apprx.sv
// Combinational 4x4 approximate multiplier built from four 2x2 cells.
// Each 2x2 cell maps 3*3 to 7; all other digit pairs are exact.
module mul_4x4_apprx
    import apprx_alu_pkg::*;
(
    input  logic [NIB_W-1:0] a,
    input  logic [NIB_W-1:0] b,
    output logic [PP_W-1:0]  p
);

    function automatic logic [3:0] mul_2x2(input logic [1:0] x, input logic [1:0] y);
        if (x == 2'd3 && y == 2'd3)
            return 4'd7;
        return {2'b00, x} * {2'b00, y};
    endfunction

    logic [3:0] ll, hl, lh, hh;

    always_comb begin
        ll = mul_2x2(a[1:0], b[1:0]);
        hl = mul_2x2(a[3:2], b[1:0]);
        lh = mul_2x2(a[1:0], b[3:2]);
        hh = mul_2x2(a[3:2], b[3:2]);
        p  = {4'b0000, ll}
           + ({4'b0000, hl} << 2)
           + ({4'b0000, lh} << 2)
           + ({4'b0000, hh} << 4);
    end

endmodule

// File: rtl/mul_8x8_apprx_seq.sv
// Sequential 8x8 approximate multiplier: one 4x4 cell reused over four nibble steps.
// Optional APPRX_MUL_EXACT_EN adds a latched exact-mode select.
module mul_8x8_apprx_seq
    import apprx_alu_pkg::*;
(
    input  logic                clk,
    input  logic                rst,
    mul_8x8_apprx_seq_if.slave  bus
);

    state_t              state, state_nxt;
    logic [STEP_W-1:0]   step;
    logic [OP_W-1:0]     a_r, b_r;
    logic [PROD_W-1:0]   acc;
    logic [NIB_W-1:0]    a_nib, b_nib;
    logic [PP_W-1:0]     cell_p, pp;
    logic [PROD_W-1:0]   pp_sh;
    logic                accept;
`ifdef APPRX_MUL_EXACT_EN
    logic                exact_r;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        accept    = 1'b0;
        case (state)
            IDLE: if (bus.in_valid) begin
                accept    = 1'b1;
                state_nxt = RUN;
            end
            RUN:  if (step == STEP_LAST) state_nxt = DONE;
            DONE: if (bus.out_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    assign bus.in_ready  = (state == IDLE);
    assign bus.out_valid = (state == DONE);
    assign bus.busy      = (state == RUN) || (state == DONE);
    assign bus.P         = acc;

    // step[0] picks the A nibble, step[1] the B nibble
    assign a_nib = step[0] ? a_r[7:4] : a_r[3:0];
    assign b_nib = step[1] ? b_r[7:4] : b_r[3:0];

    mul_4x4_apprx u_cell (
        .a (a_nib),
        .b (b_nib),
        .p (cell_p)
    );

    always_comb begin
        pp = cell_p;
`ifdef APPRX_MUL_EXACT_EN
        if (exact_r)
            pp = {{NIB_W{1'b0}}, a_nib} * {{NIB_W{1'b0}}, b_nib};
`endif
        pp_sh = {{(PROD_W-PP_W){1'b0}}, pp} << step_shift(step);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_r     <= '0;
            b_r     <= '0;
            acc     <= '0;
            step    <= '0;
`ifdef APPRX_MUL_EXACT_EN
            exact_r <= 1'b0;
`endif
        end else if (accept) begin
            a_r     <= bus.A;
            b_r     <= bus.B;
            acc     <= '0;
            step    <= '0;
`ifdef APPRX_MUL_EXACT_EN
            exact_r <= bus.exact;
`endif
        end else if (state == RUN) begin
            acc <= acc + pp_sh;
            if (step != STEP_LAST)
                step <= step + 1'b1;
        end
    end

endmodule

// File: doc/mul_8x8_apprx_seq.md
# mul_8x8_apprx_seq

Sequential 8×8 unsigned approximate multiplier for the approximate ALU datapath. It time-multiplexes one `mul_4x4_apprx` instance over four nibble-pair steps and accumulates the shifted 8-bit partial products into a 16-bit result. It sits directly upstream of the 4×4 cell: it feeds the cell its nibble operands and consumes the cell's 8-bit product each cycle. Operand and result transfers use valid/ready handshakes toward the ALU issue and writeback stages.

## Interface
- Parameters: none; all widths are fixed at 8-bit operands and a 16-bit product.
- One clock and one reset. The reset is asynchronous and active-high.
- `clk` input 1: rising-edge clock.
- `rst` input 1: asynchronous active-high reset.
- `in_valid` input 1: the operand pair is valid.
- `in_ready` output 1: the block can accept operands. High only in IDLE.
- `A` input 8: multiplicand.
- `B` input 8: multiplier.
- `exact` input 1: selects exact partial products. This port exists only under `APPRX_MUL_EXACT_EN`.
- `out_valid` output 1: `P` holds a completed product.
- `out_ready` input 1: the consumer accepts `P`.
- `P` output 16: the accumulated product.
- `busy` output 1: high in RUN or DONE.

## Operation
- The FSM has three states: IDLE, RUN and DONE.
- IDLE:
  - `in_ready`=1.
  - On `in_valid && in_ready`, latch `A` and `B` (and `exact` if present), clear the accumulator, set step=0 and go to RUN.
- RUN: a 2-bit step counter selects the nibble pair and the shift, one step per cycle.
  - Step 0: `A[3:0]`×`B[3:0]`, shift 0.
  - Step 1: `A[7:4]`×`B[3:0]`, shift 4.
  - Step 2: `A[3:0]`×`B[7:4]`, shift 4.
  - Step 3: `A[7:4]`×`B[7:4]`, shift 8.
  - Each cycle: acc ← acc + (pp << shift), where pp is the 8-bit output of the 4×4 cell.
  - After step 3, go to DONE. The counter does not wrap inside RUN.
- Arithmetic: the accumulator is 16 bits unsigned. The maximum exact sum is 65025, so no overflow is possible. Approximate results are never larger than exact ones. No saturation logic is required.
- DONE:
  - `out_valid`=1 and `P`=acc, both held stable until `out_ready`=1.
  - On `out_ready`, go to IDLE.
  - `out_ready` asserted in other states is ignored.
- Operand registers are loaded only on the input handshake. Changes on `A` and `B` during RUN or DONE have no effect.
- Reset, whether idle or mid-operation, immediately forces:
  - state IDLE, step 0, accumulator 0, operand registers 0;
  - `in_ready`=1, `out_valid`=0, `busy`=0, `P`=0.
- Any in-flight operation is discarded.
- Reset values of all outputs: `in_ready`=1, `out_valid`=0, `busy`=0, `P`=0x0000.

## Timing
- The input handshake happens at clock edge t.
- Accumulation happens at edges t+1 through t+4.
- `out_valid` rises after edge t+4, giving a latency of 4 cycles from acceptance to result.
- If `out_ready` is already high when DONE is entered, the output handshake occurs at edge t+5. IDLE is re-entered and the next operand can be accepted at t+6.
- Sustained throughput is one product per 6 cycles.
- `in_ready`, `out_valid` and `busy` are decoded directly from registered state, with no combinational path from the inputs.
- The 4×4 cell is combinational between the operand registers and the accumulator adder. This is a single-cycle path.

## Configuration
- The macro is `APPRX_MUL_EXACT_EN`.
- When defined:
  - The `exact` port exists and is latched on acceptance.
  - When the latched `exact`=1, each partial product is the exact 4×4 product (native multiply) instead of the cell output.
  - When the latched `exact`=0, behaviour is identical to the undefined case.
- When undefined: there is no `exact` port, and every step uses `mul_4x4_apprx`.

## Structure
- The shared package `apprx_alu_pkg` holds:
  - the state enum (IDLE, RUN, DONE);
  - the step width constant (2);
  - the shift-per-step constants (0, 4, 4, 8);
  - the width constants (operand 8, nibble 4, product 16).
- Sub-modules: instantiate exactly one existing `mul_4x4_apprx`. No new sub-module is needed. The nibble mux and the shift are inline logic.

## Test plan
- **Reset:** assert `rst` mid-RUN (after step 1) → outputs immediately `in_ready`=1, `out_valid`=0, `busy`=0, `P`=0. A fresh operation afterwards completes correctly.
- **No-approximation operands:** `A`=0x12, `B`=0x21 → `P`=0x0252 (594) after 4 cycles. No 2-bit digit pair of the operands is 3·3, so the result is exact.
- **Worst case:** `A`=0xFF, `B`=0xFF, with the team's 2×2 cell mapping 3·3→7 → `P`=0xC58F (50575).
  - Each partial product is 175.
  - Under `APPRX_MUL_EXACT_EN` with `exact`=1, the result is 0xFE01.
- **Backpressure:** `A`=0x0F, `B`=0x0F with `out_ready` held low for 5 cycles →
  - `P`=0x00AF (175) stays stable;
  - `in_ready` stays 0, and an `in_valid` pulse during this time is ignored;
  - the output handshake occurs on the first cycle `out_ready`=1.
- **Back-to-back:** `in_valid` held high with `A`=0x10, `B`=0x10 and then 0x00 × 0xAB, with `out_ready`=1 →
  - results 0x0100, then 0x0000;
  - second acceptance exactly 6 cycles after the first.
- **Operand stability:** toggle `A` and `B` randomly during RUN → `P` depends only on the values latched at acceptance.
